// File: rtl/vision_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package    : vision_pkg                                            |
// | Description: Shared types and constants for the vision control     |
// |              filter (action FSM states, action and lane codes).    |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
package vision_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        HOLD         = 2'd1,
        WAIT_RELEASE = 2'd2
    } action_state_t;

    localparam int ACTION_JUMP = 0;
    localparam int ACTION_DUCK = 1;

    localparam logic [1:0] LANE_LEFT  = 2'd0;
    localparam logic [1:0] LANE_MID   = 2'd1;
    localparam logic [1:0] LANE_RIGHT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vision_action_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : vision_action_timer                                   |
// | Description: One action channel: IDLE / HOLD / WAIT_RELEASE FSM    |
// |              with a minimum-hold down-counter. A start is taken    |
// |              only when i_allow_start is high.                      |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module vision_action_timer
    import vision_pkg::*;
#(
    parameter int HOLD_CYCLES = 32_500_000,
    parameter int TIMER_W     = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  logic i_sample,
    input  logic i_allow_start,
    output logic o_start_req,
    output logic o_busy,
    output logic o_action,
    output logic o_action_start
);

    localparam logic [1:0]         c_st_idle   = IDLE;
    localparam logic [1:0]         c_st_hold   = HOLD;
    localparam logic [1:0]         c_st_wait   = WAIT_RELEASE;
    localparam logic [TIMER_W-1:0] c_hold_load = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_timer_one = TIMER_W'(1);

    logic [1:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_raw;
    logic               r_action;
    logic               r_action_start;
    logic               w_sample_eff;
    logic               w_start_req;

    // A strobe in the current cycle overrides the latched sample.
    assign w_sample_eff   = i_valid ? i_sample : r_raw;
    assign w_start_req    = i_valid && i_sample && (r_state == c_st_idle);
    assign o_start_req    = w_start_req;
    assign o_busy         = (r_state != c_st_idle);
    assign o_action       = r_action;
    assign o_action_start = r_action_start;

    // Channel FSM, hold timer, latched raw sample and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_timer        <= '0;
            r_raw          <= 1'b0;
            r_action       <= 1'b0;
            r_action_start <= 1'b0;
        end else begin
            r_action_start <= 1'b0;
            if (i_valid) begin
                r_raw <= i_sample;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_start_req && i_allow_start) begin
                        r_state        <= c_st_hold;
                        r_timer        <= c_hold_load;
                        r_action       <= 1'b1;
                        r_action_start <= 1'b1;
                    end
                end
                c_st_hold: begin
                    // Free-running countdown; new rises do not reload it.
                    if (r_timer != '0) begin
                        r_timer <= r_timer - c_timer_one;
                    end else if (w_sample_eff) begin
                        r_state <= c_st_wait;
                    end else begin
                        r_state  <= c_st_idle;
                        r_action <= 1'b0;
                    end
                end
                c_st_wait: begin
                    if (i_valid && !i_sample) begin
                        r_state  <= c_st_idle;
                        r_action <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_timer  <= '0;
                    r_action <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vision_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : vision_filter                                         |
// | Description: Debouncer/filter for camera-derived player controls.  |
// |              Commits a lane after LANE_STABLE consistent strobes   |
// |              and stretches each action to a minimum hold time.     |
// |              Option macro VISION_FILTER_MUTEX_EN: at most one      |
// |              action channel active at a time (lowest index wins).  |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module vision_filter
    import vision_pkg::*;
#(
    parameter int LANE_W      = 2,
    parameter int LANE_RESET  = int'(LANE_MID),
    parameter int LANE_STABLE = 3,
    parameter int NUM_ACTIONS = 2,
    parameter int HOLD_CYCLES = 32_500_000
) (
    input  logic                   system_clock_in,
    input  logic                   system_reset,
    input  logic                   vision_data_valid,
    input  logic [LANE_W-1:0]      lane_in,
    input  logic [NUM_ACTIONS-1:0] action_in,
    output logic [LANE_W-1:0]      lane,
    output logic                   lane_changed,
    output logic [NUM_ACTIONS-1:0] action,
    output logic [NUM_ACTIONS-1:0] action_start
);

    localparam int                  c_cnt_w      = $clog2(LANE_STABLE + 1);
    localparam logic [c_cnt_w-1:0]  c_stable     = c_cnt_w'(LANE_STABLE);
    localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);
    localparam logic [LANE_W-1:0]   c_lane_reset = LANE_W'(LANE_RESET);

    logic [LANE_W-1:0]      r_lane;
    logic [LANE_W-1:0]      r_cand;
    logic [c_cnt_w-1:0]     r_count;
    logic                   r_lane_changed;
    logic [c_cnt_w-1:0]     w_count_inc;
    logic [NUM_ACTIONS-1:0] w_start_req;
    logic [NUM_ACTIONS-1:0] w_busy;
    logic [NUM_ACTIONS-1:0] w_allow_start;

    assign lane         = r_lane;
    assign lane_changed = r_lane_changed;
    assign w_count_inc  = r_count + c_cnt_one;

    // Lane debounce: a new candidate must repeat LANE_STABLE times to commit.
    always_ff @(posedge system_clock_in) begin
        if (system_reset) begin
            r_lane         <= c_lane_reset;
            r_cand         <= c_lane_reset;
            r_count        <= '0;
            r_lane_changed <= 1'b0;
        end else begin
            r_lane_changed <= 1'b0;
            if (vision_data_valid) begin
                if (lane_in == r_lane) begin
                    r_count <= '0;
                end else if (lane_in == r_cand) begin
                    if (w_count_inc == c_stable) begin
                        r_lane         <= r_cand;
                        r_lane_changed <= 1'b1;
                        r_count        <= '0;
                    end else begin
                        r_count <= w_count_inc;
                    end
                end else begin
                    r_cand <= lane_in;
                    // A one-strobe threshold commits the fresh candidate at once.
                    if (c_cnt_one == c_stable) begin
                        r_lane         <= lane_in;
                        r_lane_changed <= 1'b1;
                        r_count        <= '0;
                    end else begin
                        r_count <= c_cnt_one;
                    end
                end
            end
        end
    end

`ifdef VISION_FILTER_MUTEX_EN
    logic w_blocked;

    // Arbitration: any active channel blocks all starts; among simultaneous
    // requests the lowest index is granted.
    always_comb begin
        w_blocked     = |w_busy;
        w_allow_start = '0;
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            w_allow_start[i] = !w_blocked;
            w_blocked        = w_blocked | w_start_req[i];
        end
    end
`else
    logic w_unused_arb;

    assign w_allow_start = '1;
    assign w_unused_arb  = ^{w_busy, w_start_req};
`endif

    for (genvar gi = 0; gi < NUM_ACTIONS; gi++) begin : g_action
        vision_action_timer #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_timer (
            .clk            (system_clock_in),
            .rst            (system_reset),
            .i_valid        (vision_data_valid),
            .i_sample       (action_in[gi]),
            .i_allow_start  (w_allow_start[gi]),
            .o_start_req    (w_start_req[gi]),
            .o_busy         (w_busy[gi]),
            .o_action       (action[gi]),
            .o_action_start (action_start[gi])
        );
    end

endmodule
`default_nettype wire
